// File: rtl/spi_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_link_pkg
// Description : Shared SPI link constants, frame field layout and rx FSM states.
// Revision    : 1.0
// ============================================================================
package spi_link_pkg;

    localparam int LINK_FRAME_BITS = 16;
    localparam int LINK_DATA_W     = 14;
    localparam int LINK_MAX_VALUE  = 9999;

    // Frame layout: reserved bits above the payload must be transmitted as 0.
    localparam int RSV_MSB = LINK_FRAME_BITS - 1;
    localparam int RSV_LSB = LINK_DATA_W;
    localparam int PAY_MSB = LINK_DATA_W - 1;
    localparam int PAY_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge
// Description : N-stage synchronizer with single-cycle rise/fall pulse outputs.
// Revision    : 1.0
// ============================================================================
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_dly;

    // Reset to the line's idle level so release never fabricates an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= {STAGES{RST_VAL}};
            r_dly  <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_dly  <= r_sync[STAGES-1];
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_rise =  r_sync[STAGES-1] & ~r_dly;
    assign o_fall = ~r_sync[STAGES-1] &  r_dly;

endmodule
`default_nettype wire

// File: rtl/spi_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_rx
// Description : SPI mode-0 slave deframer; validates 16-bit frames into a
//               14-bit counter value and returns the last value on miso.
// Revision    : 1.0
// ============================================================================
module spi_frame_rx
    import spi_link_pkg::*;
#(
    parameter int DATA_W      = LINK_DATA_W,
    parameter int FRAME_BITS  = LINK_FRAME_BITS,
    parameter int MAX_VALUE   = LINK_MAX_VALUE,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              ss,
    output logic              miso,
    output logic [DATA_W-1:0] o_counter,
    output logic              o_data_valid,
    output logic              o_frame_err,
    output logic              o_busy
);

    localparam int CNT_W = $clog2(FRAME_BITS);

    logic w_unused_sclk_lvl;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_ss_sync;
    logic w_ss_rise;
    logic w_ss_fall;
    logic w_mosi_sync;

    logic [SYNC_STAGES-1:0] r_mosi_sync;
    rx_state_t              r_state;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [FRAME_BITS-1:0]  r_shift;
    logic [FRAME_BITS-1:0]  r_tx;
    logic [DATA_W-1:0]      r_counter;
    logic                   r_valid;
    logic                   r_err;

    logic                   w_last_bit;
    logic [CNT_W-1:0]       w_cnt_next;
    logic [DATA_W-1:0]      w_payload;
    logic                   w_accept;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk    (clk),
        .reset  (reset),
        .i_d    (sclk),
        .o_sync (w_unused_sclk_lvl),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk    (clk),
        .reset  (reset),
        .i_d    (ss),
        .o_sync (w_ss_sync),
        .o_rise (w_ss_rise),
        .o_fall (w_ss_fall)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end
    assign w_mosi_sync = r_mosi_sync[SYNC_STAGES-1];

    // Bit count after this cycle's sample, used by both completion and abort.
    assign w_last_bit = (r_bit_cnt == CNT_W'(FRAME_BITS - 1));
    assign w_cnt_next = !w_sclk_rise ? r_bit_cnt :
                        (w_last_bit ? '0 : r_bit_cnt + 1'b1);

    assign w_payload = r_shift[DATA_W-1:0];
    assign w_accept  = (r_shift[FRAME_BITS-1:DATA_W] == '0) &&
                       (w_payload <= DATA_W'(MAX_VALUE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tx      <= '0;
            r_counter <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_ss_fall) begin
                        r_state   <= SHIFT;
                        r_bit_cnt <= '0;
                        r_tx      <= FRAME_BITS'(r_counter);
                    end
                end
                SHIFT: begin
                    if (w_sclk_rise) begin
                        r_shift <= {r_shift[FRAME_BITS-2:0], w_mosi_sync};
                    end
                    // The trailing fall of the previous frame must not consume the reloaded MSB.
                    if (w_sclk_fall && (r_bit_cnt != '0)) begin
                        r_tx <= {r_tx[FRAME_BITS-2:0], 1'b0};
                    end
                    r_bit_cnt <= w_cnt_next;
                    if (w_sclk_rise && w_last_bit) begin
                        r_state <= CHECK;
                    end else if (w_ss_rise) begin
                        r_state   <= IDLE;
                        r_bit_cnt <= '0;
                        r_err     <= (w_cnt_next != '0);
                    end
                end
                CHECK: begin
                    if (w_accept) begin
                        r_counter <= w_payload;
                        r_valid   <= 1'b1;
                    end else begin
                        r_err <= 1'b1;
                    end
                    if (!w_ss_sync) begin
                        r_state <= SHIFT;
                        r_tx    <= FRAME_BITS'(w_accept ? w_payload : r_counter);
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign miso         = r_tx[FRAME_BITS-1] & ~w_ss_sync;
    assign o_counter    = r_counter;
    assign o_data_valid = r_valid;
    assign o_frame_err  = r_err;
    assign o_busy       = ~w_ss_sync;

endmodule
`default_nettype wire

// File: doc/spi_frame_rx.md
Name: spi_frame_rx

Overview:
SPI slave receive front-end. It sits directly downstream of the on-board SPI master and feeds the FND display path inside the slave. It oversamples sclk/mosi/ss in the system clock domain and deframes 16-bit mode-0 MSB-first frames into a validated 14-bit counter value with a one-cycle valid pulse. It also returns the last accepted value on miso for master-side readback.

Parameters:
DATA_W, 14, width of the counter payload
FRAME_BITS, 16, bits per SPI frame; payload is in the low DATA_W bits, upper bits are reserved and must be 0
MAX_VALUE, 9999, largest accepted payload (4-digit FND limit)
SYNC_STAGES, 2, flip-flop synchronizer depth on sclk, mosi and ss

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  asynchronous, active-low reset
sclk  input  1  SPI clock from master, mode 0 (idle low, sample on rising edge)
mosi  input  1  SPI data from master
ss  input  1  slave select, active-low
miso  output  1  SPI data to master
o_counter  output  DATA_W  last accepted payload
o_data_valid  output  1  one-cycle pulse when o_counter updates
o_frame_err  output  1  one-cycle pulse when a frame is rejected
o_busy  output  1  high while ss is asserted (synchronized)

Behaviour:
- Reset (reset=0, async): o_counter=0, o_data_valid=0, o_frame_err=0, o_busy=0, miso=0, bit_cnt=0, shift/tx registers=0, FSM=IDLE.
- sclk, mosi and ss each pass through SYNC_STAGES flops. Edges are detected on the synchronized sclk/ss against a 1-cycle-delayed copy.
- FSM IDLE: waiting. On ss falling edge: go to SHIFT, clear bit_cnt, load tx_reg={reserved zeros, o_counter}, drive miso=tx_reg MSB.
- FSM SHIFT:
  - On sclk rising edge: shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi_sync}; bit_cnt++.
  - On sclk falling edge: shift tx_reg left and drive the new MSB on miso.
  - When the FRAME_BITS-th bit is sampled: go to CHECK next cycle, bit_cnt wraps to 0.
- FSM CHECK (1 cycle):
  - Accept if reserved bits are 0 and payload <= MAX_VALUE. Then o_counter <= payload and o_data_valid=1 that cycle.
  - Otherwise o_frame_err=1 and o_counter is held.
  - Next state: SHIFT if ss is still low (back-to-back frames, tx_reg reloaded with the current o_counter), else IDLE.
- Latency: the 16th sclk rising pin edge to the o_data_valid pulse is SYNC_STAGES+2 clk cycles.
- ss rising edge in SHIFT with bit_cnt != 0: abort. o_frame_err pulses 1 cycle, no update, go to IDLE. With bit_cnt == 0: go to IDLE silently.
- sclk edges while ss is high are ignored. miso=0 whenever ss_sync is high.
- sclk rising edge and ss rising edge detected in the same cycle: sample the bit first, then evaluate the abort rule on the updated bit_cnt. A completing 16th bit goes to CHECK, and CHECK then returns to IDLE.
- o_data_valid and o_frame_err are never high in the same cycle.
- Reset mid-frame discards the partial frame. No valid or err pulse is produced after reset release.
- Requirement on the master: sclk high and low periods must each be at least SYNC_STAGES+1 clk cycles.

Decomposition:
- Package spi_link_pkg holds:
  - FRAME_BITS, DATA_W and MAX_VALUE defaults, shared with the master's frame builder
  - typedef enum logic [1:0] {IDLE, SHIFT, CHECK} rx_state_t
  - the frame field positions (reserved bits [15:14], payload [13:0])
- One sub-module, sync_edge: an N-stage synchronizer plus rise/fall pulse outputs. It is instanced for sclk and for ss. mosi uses the synchronizer only.

Test Plan:
- Reset low, then release, no SPI activity -> o_counter=0 and no valid/err pulses for 1000 cycles.
- Single frame 0x04D2 (1234), sclk period 20 clk, ss low then high -> exactly one o_data_valid pulse, o_counter=1234, o_frame_err never high.
- Frame 0x2710 (10000 > MAX_VALUE), then frame 0x8005 (reserved bit set) -> two o_frame_err pulses, o_counter stays at the previous value, no valid pulses.
- ss raised after 9 bits of 0x1111 -> one o_frame_err pulse, o_counter unchanged, FSM back in IDLE. A following full 0x0007 frame -> o_counter=7.
- Back-to-back frames 0x0001 and 0x270F with ss held low -> two valid pulses, o_counter=1 then 9999. miso during the second frame shifts out 0x0001 MSB-first.
- Assert reset at bit 12 of a frame, release, then send 0x0042 -> no pulse from the aborted frame, o_counter=0x42 after the new frame.
